// File: rtl/lev_search_ctrl.sv
// lev_search_ctrl: walks a zero-terminated dictionary, feeds each word to the distance engine, keeps the best match.
// Optional LEV_EARLY_EXIT_EN: stop the scan as soon as a zero-distance word is scored.
module lev_search_ctrl #(
   parameter int ADDR_WIDTH = 16,
   parameter int DIST_WIDTH = 5,
   parameter int IDX_WIDTH  = 10
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [ADDR_WIDTH-1:0] base_addr,
   output logic                  busy,
   output logic                  done,
   output logic                  found,
   output logic                  overflow,
   output logic [DIST_WIDTH-1:0] best_dist,
   output logic [IDX_WIDTH-1:0]  best_idx,
   output logic                  mem_req,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   input  logic                  mem_ack,
   input  logic [7:0]            mem_rdata,
   output logic                  eng_valid,
   output logic [7:0]            eng_char,
   input  logic                  eng_ready,
   output logic                  eng_end,
   input  logic                  eng_dist_valid,
   input  logic [DIST_WIDTH-1:0] eng_dist
);
   typedef enum logic [2:0] {IDLE, FETCH, FEED, END, WAIT, DONE} state_t;
   state_t state, nxt;
   logic [IDX_WIDTH-1:0] idx;
   logic [7:0] len;
   logic last_word, hit;
   assign last_word = idx == {IDX_WIDTH{1'b1}};
`ifdef LEV_EARLY_EXIT_EN
   assign hit = eng_dist == '0;
`else
   assign hit = 1'b0;
`endif
   assign busy      = state == FETCH || state == FEED || state == END || state == WAIT;
   assign mem_req   = state == FETCH;
   assign eng_valid = state == FEED;
   assign eng_end   = state == END;
   always_comb begin
      nxt = state;
      case (state)
         IDLE:    nxt = start ? FETCH : IDLE;
         FETCH:   if (mem_ack) nxt = mem_rdata != 8'd0 ? FEED : (len != 8'd0 ? END : DONE);
         FEED:    if (eng_ready) nxt = FETCH;
         END:     nxt = WAIT;
         WAIT:    if (eng_dist_valid) nxt = (last_word || hit) ? DONE : FETCH;
         default: nxt = IDLE;
      endcase
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         mem_addr  <= '0;
         idx       <= '0;
         len       <= '0;
         eng_char  <= '0;
         best_dist <= '1;
         best_idx  <= '0;
         found     <= 1'b0;
         overflow  <= 1'b0;
         done      <= 1'b0;
      end else begin
         state <= nxt;
         // done rises together with entry into DONE and holds until the next accepted start
         if (nxt == DONE) done <= 1'b1;
         case (state)
            IDLE: if (start) begin
               mem_addr  <= base_addr;
               idx       <= '0;
               len       <= '0;
               found     <= 1'b0;
               overflow  <= 1'b0;
               best_dist <= '1;
               best_idx  <= '0;
               done      <= 1'b0;
            end
            FETCH: if (mem_ack && mem_rdata != 8'd0) eng_char <= mem_rdata;
            FEED: if (eng_ready) begin
               mem_addr <= mem_addr + 1'b1;
               len      <= len == 8'hff ? len : len + 1'b1;
            end
            WAIT: if (eng_dist_valid) begin
               if (eng_dist < best_dist) begin
                  best_dist <= eng_dist;
                  best_idx  <= idx;
               end
               found    <= 1'b1;
               len      <= '0;
               mem_addr <= mem_addr + 1'b1;
               if (last_word) overflow <= 1'b1;
               else idx <= idx + 1'b1;
            end
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_lev_search_ctrl.sv
// tb_lev_search_ctrl: directed checks of lev_search_ctrl with a byte memory model and a delayed-result engine model.
module tb_lev_search_ctrl;
   logic clk = 0, rst = 1, st0 = 0, st1 = 0, stall = 0, ms = 0, es = 0;
   logic [15:0] base = 0;
   logic [7:0] mem [0:65535];
   logic [4:0] dtab [0:7];
   logic busy0, done0, found0, ovf0, req0, ack0, val0, rdy0, end0, dv0 = 0;
   logic [4:0] bd0, ds0 = 0;
   logic [9:0] bi0;
   logic [15:0] addr0;
   logic [7:0] ch0, rd0;
   logic busy1, done1, found1, ovf1, req1, ack1, val1, rdy1, end1, dv1 = 0;
   logic [4:0] bd1, ds1 = 0;
   logic [1:0] bi1;
   logic [15:0] addr1;
   logic [7:0] ch1, rd1;
   int nchk = 0, nerr = 0;
   int ec0 = 0, ec1 = 0, eb0 = 0, eb1 = 0;
   int nv0 = 0, ne0 = 0, na0 = 0, sv = 0, nv1 = 0, ne1 = 0;
   int snv0, sne0, sna0, ssv, snv1, sne1, cyc, exp_ne;
   logic [15:0] alog [0:255];
   logic preq = 0, pack = 0, pval = 0, prdy = 0;
   logic [15:0] paddr = 0;
   logic [7:0] pch = 0;

   always #5 clk = ~clk;
   assign ack0 = req0 & ~ms;
   assign rdy0 = ~es;
   assign rd0  = mem[addr0];
   assign ack1 = req1 & ~ms;
   assign rdy1 = ~es;
   assign rd1  = mem[addr1];

   lev_search_ctrl u0 (
      .clk(clk), .rst(rst), .start(st0), .base_addr(base), .busy(busy0), .done(done0),
      .found(found0), .overflow(ovf0), .best_dist(bd0), .best_idx(bi0), .mem_req(req0),
      .mem_addr(addr0), .mem_ack(ack0), .mem_rdata(rd0), .eng_valid(val0), .eng_char(ch0),
      .eng_ready(rdy0), .eng_end(end0), .eng_dist_valid(dv0), .eng_dist(ds0));

   lev_search_ctrl #(.IDX_WIDTH(2)) u1 (
      .clk(clk), .rst(rst), .start(st1), .base_addr(base), .busy(busy1), .done(done1),
      .found(found1), .overflow(ovf1), .best_dist(bd1), .best_idx(bi1), .mem_req(req1),
      .mem_addr(addr1), .mem_ack(ack1), .mem_rdata(rd1), .eng_valid(val1), .eng_char(ch1),
      .eng_ready(rdy1), .eng_end(end1), .eng_dist_valid(dv1), .eng_dist(ds1));

   // engine returns the tabled distance one cycle after the end pulse; stalls are random when enabled
   always @(posedge clk) begin
      ms  <= stall ? ($urandom_range(0, 1) == 1) : 1'b0;
      es  <= stall ? ($urandom_range(0, 1) == 1) : 1'b0;
      dv0 <= end0;
      ds0 <= dtab[(ec0 - eb0) & 7];
      ec0 <= ec0 + int'(end0);
      dv1 <= end1;
      ds1 <= dtab[(ec1 - eb1) & 7];
      ec1 <= ec1 + int'(end1);
   end

   always @(negedge clk) begin
      nv0 += int'(val0 && rdy0);
      ne0 += int'(end0);
      nv1 += int'(val1 && rdy1);
      ne1 += int'(end1);
      if (ack0) begin
         alog[na0 % 256] = addr0;
         na0++;
      end
      if (req0 && preq && !pack && addr0 != paddr) sv++;
      if (val0 && pval && !prdy && ch0 != pch) sv++;
      preq = req0; pack = ack0; paddr = addr0; pval = val0; prdy = rdy0; pch = ch0;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      nchk++;
      if (got !== exp) begin
         nerr++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic load(input logic [15:0] a, input string s);
      for (int i = 0; i < s.len(); i++) mem[int'(a) + i] = s[i] == 8'h7c ? 8'h00 : s[i];
   endtask

   task automatic go(input int u, input logic [15:0] b);
      @(negedge clk);
      snv0 = nv0; sne0 = ne0; sna0 = na0; ssv = sv; snv1 = nv1; sne1 = ne1;
      eb0 = ec0; eb1 = ec1;
      base = b;
      if (u == 0) st0 = 1; else st1 = 1;
      @(negedge clk);
      st0 = 0; st1 = 0;
   endtask

   task automatic wait_done(input int u, output int c);
      c = 0;
      while (!(u == 1 ? done1 : done0) && c < 2000) begin
         @(negedge clk);
         c++;
      end
      check("timeout", c < 2000, 1);
   endtask

   initial begin
      repeat (3) @(negedge clk);
      check("rst_busy", busy0, 0);
      check("rst_done", done0, 0);
      check("rst_best_dist", bd0, 31);
      check("rst_mem_req", req0, 0);
      rst = 0;
      // two words, second is better
      load(16'h0100, "cat|dog||");
      dtab[0] = 2; dtab[1] = 1;
      go(0, 16'h0100);
      wait_done(0, cyc);
      check("t1_found", found0, 1);
      check("t1_ovf", ovf0, 0);
      check("t1_dist", bd0, 1);
      check("t1_idx", bi0, 1);
      check("t1_busy", busy0, 0);
      check("t1_chars", nv0 - snv0, 6);
      check("t1_ends", ne0 - sne0, 2);
      check("t1_reads", na0 - sna0, 9);
      for (int i = 0; i < 9; i++) check("t1_addr", alog[(sna0 + i) % 256], 32'h100 + i);
      // empty dictionary
      load(16'h0300, "|");
      go(0, 16'h0300);
      wait_done(0, cyc);
      check("t2_latency", cyc <= 3, 1);
      check("t2_found", found0, 0);
      check("t2_dist", bd0, 31);
      check("t2_chars", nv0 - snv0, 0);
      // ties under random stalls
      load(16'h0400, "ab|cd|ef||");
      dtab[0] = 3; dtab[1] = 3; dtab[2] = 3;
      stall = 1;
      go(0, 16'h0400);
      wait_done(0, cyc);
      stall = 0;
      check("t3_dist", bd0, 3);
      check("t3_idx", bi0, 0);
      check("t3_stable", sv - ssv, 0);
      check("t3_reads", na0 - sna0, 10);
      check("t3_ends", ne0 - sne0, 3);
      // exact match in the middle
      load(16'h0500, "x|y|z||");
      dtab[0] = 4; dtab[1] = 0; dtab[2] = 2;
`ifdef LEV_EARLY_EXIT_EN
      exp_ne = 2;
`else
      exp_ne = 3;
`endif
      go(0, 16'h0500);
      wait_done(0, cyc);
      check("t4_dist", bd0, 0);
      check("t4_idx", bi0, 1);
      check("t4_ends", ne0 - sne0, exp_ne);
      // reset during FEED of word 1
      dtab[0] = 2; dtab[1] = 1;
      go(0, 16'h0100);
      cyc = 0;
      while (!(val0 && ne0 - sne0 == 1) && cyc < 200) begin
         @(negedge clk);
         cyc++;
      end
      check("t5_reach_feed", cyc < 200, 1);
      rst = 1;
      @(negedge clk);
      check("t5_busy", busy0, 0);
      check("t5_done", done0, 0);
      check("t5_found", found0, 0);
      check("t5_ovf", ovf0, 0);
      check("t5_dist", bd0, 31);
      check("t5_idx", bi0, 0);
      check("t5_req", req0, 0);
      check("t5_addr", addr0, 0);
      check("t5_valid", val0, 0);
      check("t5_char", ch0, 0);
      check("t5_end", end0, 0);
      rst = 0;
      // fresh start, with an ignored start pointing at the empty list
      go(0, 16'h0100);
      repeat (4) @(negedge clk);
      base = 16'h0300; st0 = 1;
      @(negedge clk);
      st0 = 0;
      wait_done(0, cyc);
      check("t6_found", found0, 1);
      check("t6_dist", bd0, 1);
      check("t6_idx", bi0, 1);
      check("t6_reads", na0 - sna0, 9);
      // word counter saturation with a 2-bit index
      load(16'h0600, "a|b|c|d|e||");
      dtab[0] = 3; dtab[1] = 2; dtab[2] = 1; dtab[3] = 2; dtab[4] = 0;
      go(1, 16'h0600);
      wait_done(1, cyc);
      check("t7_ovf", ovf1, 1);
      check("t7_found", found1, 1);
      check("t7_dist", bd1, 1);
      check("t7_idx", bi1, 2);
      check("t7_chars", nv1 - snv1, 4);
      check("t7_ends", ne1 - sne1, 4);
      repeat (3) @(negedge clk);
      check("t7_hold_done", done1, 1);
      check("t7_no_5th", nv1 - snv1, 4);
      $display("Result: errors=%0d of %0d checks", nerr, nchk);
      $finish;
   end
endmodule
